// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Optional signed saturation of the result is enabled by defining CSKIP_SAT_EN.
`timescale 1ns/1ps
module cskip_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NG     = WIDTH / BLOCK;
    localparam int STAGES = NG / GPS;

    generate
        if ((WIDTH % BLOCK) != 0 || (NG % GPS) != 0) begin : g_param_check
            $error("cskip_adder_pipe: WIDTH must be a multiple of BLOCK and NG a multiple of GPS");
        end
    endgenerate

    // Ripple through one group; the skip path uses XOR-propagate so a
    // generate-and-kill pattern can never be mistaken for a pass-through.
    function automatic logic [BLOCK:0] skip_group(input logic [BLOCK-1:0] ga,
                                                  input logic [BLOCK-1:0] gb,
                                                  input logic             gc);
        logic             c;
        logic [BLOCK-1:0] s;
        logic             p;
        c = gc;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = ga[i] ^ gb[i] ^ c;
            c    = (ga[i] & gb[i]) | (c & (ga[i] ^ gb[i]));
        end
        p = &(ga ^ gb);
        return {c | (p & gc), s};
    endfunction

`ifdef CSKIP_SAT_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic             adv;
    logic             vld_p  [STAGES];
    logic [WIDTH-1:0] a_p    [STAGES];
    logic [WIDTH-1:0] b_p    [STAGES];
    logic [WIDTH-1:0] sum_p  [STAGES];
    logic             cry_p  [STAGES];

    logic             v_in   [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic [WIDTH-1:0] sum_nx [STAGES];
    logic             cry_nx [STAGES];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_nx;
    logic [WIDTH-1:0] sum_fin;

    assign out_valid = vld_p[STAGES-1];
    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = a;
        b_in[0] = op_sub ? ~b : b;
        c_in[0] = op_sub | cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = vld_p[k-1];
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            c_in[k] = cry_p[k-1];
            s_in[k] = sum_p[k-1];
        end
    end

    always_comb begin
        logic             c;
        logic [BLOCK:0]   grp;
        int               idx;
        c   = 1'b0;
        grp = '0;
        idx = 0;
        for (int k = 0; k < STAGES; k++) begin
            c         = c_in[k];
            sum_nx[k] = s_in[k];
            for (int g = 0; g < GPS; g++) begin
                idx = (k * GPS + g) * BLOCK;
                grp = skip_group(a_in[k][idx +: BLOCK], b_in[k][idx +: BLOCK], c);
                sum_nx[k][idx +: BLOCK] = grp[BLOCK-1:0];
                c = grp[BLOCK];
            end
            cry_nx[k] = c;
        end
    end

    assign ovf_nx = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
                    (sum_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);

`ifdef CSKIP_SAT_EN
    assign sum_fin = ovf_nx ? sat_value(a_in[STAGES-1][WIDTH-1]) : sum_nx[STAGES-1];
`else
    assign sum_fin = sum_nx[STAGES-1];
`endif

    // Stage boundary: valid bits and the visible result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) vld_p[k] <= v_in[k];
            sum_q  <= sum_fin;
            cout_q <= cry_nx[STAGES-1];
            ovf_q  <= ovf_nx;
        end
    end

    // Stage boundary: intermediate operands, partial sums and carries
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k]   <= a_in[k];
                b_p[k]   <= b_in[k];
                sum_p[k] <= sum_nx[k];
                cry_p[k] <= cry_nx[k];
            end
        end
    end
endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Self-checking bench for cskip_adder_pipe: reference model from signed/unsigned
// integer arithmetic, scoreboard queue, directed, backpressure, random and reset phases.
`timescale 1ns/1ps
module tb_cskip_adder_pipe;
    localparam int W = 32;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    cskip_adder_pipe #(.WIDTH(W), .BLOCK(4), .GPS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_popped = 0;
    logic [33:0] exp_q[$];
    logic        hold_prev = 1'b0;
    logic [33:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {cout, ovf, sum} from plain integer arithmetic
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sub);
        longint      sx, sy, sr;
        logic        co, ov;
        logic [31:0] s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sub) begin
            sr = sx - sy;
            co = (x >= y);
        end else begin
            sr = sx + sy + longint'(ci);
            co = ((64'(x) + 64'(y) + 64'(ci)) >> 32) != 64'd0;
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        s  = sr[31:0];
`ifdef CSKIP_SAT_EN
        if (ov) s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {co, ov, s};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(out_ready || !out_valid));
            if (hold_prev) chk("held_result", 64'({out_valid, cout, ovf, sum}), 64'({1'b1, held}));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("result", 64'({cout, ovf, sum}), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_popped++;
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = {cout, ovf, sum};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, op_sub));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sub);
        int t;
        a = x; b = y; cin = ci; op_sub = sub; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p0, cnt;
        bit  rdone;

        chk("pin_add",     64'(model(32'h5, 32'h3, 1'b0, 1'b0)),          64'({2'b00, 32'h0000_0008}));
        chk("pin_skip",    64'(model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)),  64'({2'b10, 32'h0000_0000}));
        chk("pin_sub",     64'(model(32'h3, 32'h5, 1'b0, 1'b1)),          64'({2'b00, 32'hFFFF_FFFE}));
`ifdef CSKIP_SAT_EN
        chk("pin_ovf",     64'(model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)),  64'({2'b01, 32'h7FFF_FFFF}));
        chk("pin_sub_ovf", 64'(model(32'h8000_0000, 32'h1, 1'b0, 1'b1)),  64'({2'b11, 32'h8000_0000}));
`else
        chk("pin_ovf",     64'(model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)),  64'({2'b01, 32'h8000_0000}));
        chk("pin_sub_ovf", 64'(model(32'h8000_0000, 32'h1, 1'b0, 1'b1)),  64'({2'b11, 32'h7FFF_FFFF}));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum",       64'(sum),       64'd0);
        chk("reset_cout",      64'(cout),      64'd0);
        chk("reset_ovf",       64'(ovf),       64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
        send(32'h7FFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        drain();

        p0 = n_popped;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'(i & 1), 1'(i >> 2));
            end
            begin
                int t;
                t = 0;
                @(posedge clk);
                #1;
                while (!out_valid && t < 30) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("bp_first_result", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(n_popped - p0), 64'd6);

        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        send(32'h0000_0030, 32'h0000_0001, 1'b0, 1'b1);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 30) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_sum",       64'(sum),       64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_result", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0);
        cnt = 1;
        @(negedge clk);
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("latency_after_reset", 64'(cnt), 64'(L));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
